hazard_control_unit: RTL and testbench

//  Pipeline sequencer for the 16-bit MISC-V core. Sits beside Decode_Stage and

---
 rtl/hazard_control_unit_pkg.sv | 32 +++
 rtl/hcu_shadow_pipe.sv | 28 ++
 rtl/hazard_control_unit.sv | 139 +++++++++++++
 tb/tb_hazard_control_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the hazard control unit: FSM state codes,
// EX-stage forwarding select codes, shadow-entry layout and the
// destination-match helper used by the stall and forwarding logic.
package hazard_control_unit_pkg;

    localparam int HCU_REG_ADDR_W = 3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } hcu_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // One in-flight destination record: {valid, rd, regwrite, memread}
    typedef struct packed {
        logic                      valid;
        logic [HCU_REG_ADDR_W-1:0] rd;
        logic                      regwrite;
        logic                      memread;
    } shadow_t;

    // True when stage s will write register r; x0 never matches
    function automatic logic dest_match(input logic [HCU_REG_ADDR_W-1:0] r,
                                        input shadow_t s);
        return s.valid & s.regwrite & (s.rd == r) & (r != '0);
    endfunction

endpackage

// File: rtl/hcu_shadow_pipe.sv
// Three-deep shadow of the EX, MEM and WB destination info. MEM and WB
// always follow the stage ahead; EX takes the ID entry or a bubble.
module hcu_shadow_pipe
    import hazard_control_unit_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  shadow_t id_entry,
    input  logic    insert_bubble,
    output shadow_t ex,
    output shadow_t mem,
    output shadow_t wb
);

    // Shift the shadow pipe every edge; a bubble clears the EX entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex  <= '0;
            mem <= '0;
            wb  <= '0;
        end else begin
            wb  <= mem;
            mem <= ex;
            ex  <= insert_bubble ? shadow_t'('0) : id_entry;
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer for the 16-bit MISC-V core: load-use and branch
// stalls, jump flush, decode comparator forwarding and registered EX
// forwarding selects. Define HAZARD_PERF_EN to add saturating stall and
// flush counters (stall_count, flush_count).
//
// Handshake: stall holds PC and IF/ID (pc_write=ifid_write=0) and inserts
// an ID/EX bubble in the same cycle; flush only ever happens when not
// stalled, and the instruction arriving in ID right after a flush is
// treated as invalid.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int REG_ADDR_W = HCU_REG_ADDR_W
`ifdef HAZARD_PERF_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  id_is_branch,
    input  logic                  id_jump,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic                  comparatorMux1Control,
    output logic                  comparatorMux2Control,
    output logic [1:0]            ex_fwd_a_sel,
    output logic [1:0]            ex_fwd_b_sel,
    output logic [1:0]            hcu_state
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
`endif
);

    hcu_state_t state_q, state_d;
    shadow_t    ex_s, mem_s, wb_s, id_entry;
    logic       idv, stall, flush;
    logic       ex_hit1, ex_hit2, mem_hit1, mem_hit2;
    logic [1:0] fwd_a_d, fwd_b_d, fwd_a_q, fwd_b_q;

    hcu_shadow_pipe u_shadow (
        .clk           (clk),
        .reset         (reset),
        .id_entry      (id_entry),
        .insert_bubble (stall),
        .ex            (ex_s),
        .mem           (mem_s),
        .wb            (wb_s)
    );

    // The register file writes in the first half-cycle, so WB never needs
    // a forward; its shadow entry has no consumer here.
    logic unused_wb;
    assign unused_wb = ^wb_s;

    // Hazard detection, forwarding selection, outputs and next state
    always_comb begin
        idv      = id_valid & (state_q != ST_FLUSH);
        ex_hit1  = id_use_rs1 & dest_match(id_rs1, ex_s);
        ex_hit2  = id_use_rs2 & dest_match(id_rs2, ex_s);
        mem_hit1 = id_use_rs1 & dest_match(id_rs1, mem_s);
        mem_hit2 = id_use_rs2 & dest_match(id_rs2, mem_s);

        stall = idv & (((ex_hit1 | ex_hit2) & ex_s.memread) |
                       (id_is_branch & ((ex_hit1 | ex_hit2) |
                                        ((mem_hit1 | mem_hit2) & mem_s.memread))));
        flush = id_jump & idv & ~stall;

        pc_write    = ~stall;
        ifid_write  = ~stall;
        idex_bubble = stall;
        ifid_flush  = flush;

        comparatorMux1Control = ~(id_is_branch & ~stall & mem_hit1 & ~mem_s.memread);
        comparatorMux2Control = ~(id_is_branch & ~stall & mem_hit2 & ~mem_s.memread);

        id_entry = '{valid: idv, rd: id_rd, regwrite: id_regwrite, memread: id_memread};

        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (idv && !stall) begin
            if (ex_hit1 && !ex_s.memread) fwd_a_d = FWD_MEM;
            else if (mem_hit1)            fwd_a_d = FWD_WB;
            if (ex_hit2 && !ex_s.memread) fwd_b_d = FWD_MEM;
            else if (mem_hit2)            fwd_b_d = FWD_WB;
        end

        state_d = ST_RUN;
        if (stall)      state_d = ST_STALL;
        else if (flush) state_d = ST_FLUSH;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // EX-stage forwarding selects follow the instruction into EX
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign ex_fwd_a_sel = fwd_a_q;
    assign ex_fwd_b_sel = fwd_b_q;
    assign hcu_state    = state_q;

`ifdef HAZARD_PERF_EN
    // Saturating event counters for stall and flush cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && stall_count != {CNT_W{1'b1}}) stall_count <= stall_count + 1'b1;
            if (flush && flush_count != {CNT_W{1'b1}}) flush_count <= flush_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomized and directed bench for hazard_control_unit against a
// stage-list reference model.
module tb_hazard_control_unit;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [2:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2, id_regwrite, id_memread, id_is_branch, id_jump;
    logic       pc_write, ifid_write, ifid_flush, idex_bubble;
    logic       cmp1, cmp2;
    logic [1:0] ex_fwd_a_sel, ex_fwd_b_sel, hcu_state;
`ifdef HAZARD_PERF_EN
    logic [15:0] stall_count, flush_count;
`endif

    hazard_control_unit dut (
        .clk                   (clk),
        .reset                 (reset),
        .id_valid              (id_valid),
        .id_rs1                (id_rs1),
        .id_rs2                (id_rs2),
        .id_rd                 (id_rd),
        .id_use_rs1            (id_use_rs1),
        .id_use_rs2            (id_use_rs2),
        .id_regwrite           (id_regwrite),
        .id_memread            (id_memread),
        .id_is_branch          (id_is_branch),
        .id_jump               (id_jump),
        .pc_write              (pc_write),
        .ifid_write            (ifid_write),
        .ifid_flush            (ifid_flush),
        .idex_bubble           (idex_bubble),
        .comparatorMux1Control (cmp1),
        .comparatorMux2Control (cmp2),
        .ex_fwd_a_sel          (ex_fwd_a_sel),
        .ex_fwd_b_sel          (ex_fwd_b_sel),
        .hcu_state             (hcu_state)
`ifdef HAZARD_PERF_EN
        ,
        .stall_count           (stall_count),
        .flush_count           (flush_count)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: list of in-flight instructions by stage
    typedef struct packed {bit v; bit [2:0] rd; bit rw; bit ld;} ent_t;
    ent_t m_ex, m_mem;
    bit       m_after_flush;
    int       m_fa, m_fb, m_state;
    int       m_sc, m_fc;
    bit       last_stall, last_flush;
    int       stalls_seen;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit writes_to(input ent_t e, input bit [2:0] r);
        return e.v && e.rw && e.rd == r && r != 0;
    endfunction

    task automatic model_clear();
        m_ex = '0; m_mem = '0; m_after_flush = 0;
        m_fa = 0; m_fb = 0; m_state = 0; m_sc = 0; m_fc = 0;
    endtask

    // One ID cycle: drive, check against the model, then advance the model
    task automatic step(input bit v, input bit [2:0] r1, input bit [2:0] r2, input bit [2:0] rd,
                        input bit u1, input bit u2, input bit rw, input bit ld,
                        input bit br, input bit jp);
        bit [2:0] src [2];
        bit       used [2];
        int       e_cmp [2];
        int       n_f [2];
        bit       idv, e_stall, e_flush;
        @(negedge clk);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_use_rs1 = u1; id_use_rs2 = u2; id_regwrite = rw; id_memread = ld;
        id_is_branch = br; id_jump = jp;
        #1;
        src[0] = r1; src[1] = r2; used[0] = u1; used[1] = u2;
        idv = v && !m_after_flush;
        e_stall = 0;
        for (int i = 0; i < 2; i++) begin
            if (used[i]) begin
                // producer one ahead: a load is not ready; a branch compares too early for anything
                if (writes_to(m_ex, src[i]) && (m_ex.ld || br)) e_stall = 1;
                // producer two ahead: a load result is not ready for the decode comparator
                if (br && writes_to(m_mem, src[i]) && m_mem.ld) e_stall = 1;
            end
        end
        e_stall = e_stall && idv;
        e_flush = jp && idv && !e_stall;
        for (int i = 0; i < 2; i++) begin
            e_cmp[i] = (br && !e_stall && used[i] && writes_to(m_mem, src[i]) && !m_mem.ld) ? 0 : 1;
            n_f[i] = 0;
            if (idv && !e_stall && used[i]) begin
                if (writes_to(m_ex, src[i]))       n_f[i] = 1;
                else if (writes_to(m_mem, src[i])) n_f[i] = 2;
            end
        end
        chk("pc_write", pc_write, !e_stall);
        chk("ifid_write", ifid_write, !e_stall);
        chk("idex_bubble", idex_bubble, e_stall);
        chk("ifid_flush", ifid_flush, e_flush);
        chk("cmp1", cmp1, e_cmp[0]);
        chk("cmp2", cmp2, e_cmp[1]);
        chk("fwd_a", ex_fwd_a_sel, m_fa);
        chk("fwd_b", ex_fwd_b_sel, m_fb);
        chk("state", hcu_state, m_state);
`ifdef HAZARD_PERF_EN
        chk("stall_count", stall_count, m_sc);
        chk("flush_count", flush_count, m_fc);
`endif
        last_stall = e_stall;
        last_flush = ifid_flush;
        @(posedge clk);
        m_mem = m_ex;
        m_ex = e_stall ? ent_t'('0) : ent_t'({idv, rd, rw, ld});
        m_fa = n_f[0];
        m_fb = n_f[1];
        m_state = e_stall ? 1 : (e_flush ? 2 : 0);
        m_after_flush = e_flush;
        if (e_stall && m_sc != 65535) m_sc++;
        if (e_flush && m_fc != 65535) m_fc++;
    endtask

    // Present an instruction and hold it in ID while stalled (bounded)
    task automatic issue(input bit [2:0] r1, input bit [2:0] r2, input bit [2:0] rd,
                         input bit u1, input bit u2, input bit rw, input bit ld,
                         input bit br, input bit jp);
        int n;
        stalls_seen = 0;
        step(1, r1, r2, rd, u1, u2, rw, ld, br, jp);
        n = 0;
        while (last_stall && n < 6) begin
            stalls_seen++;
            n++;
            step(1, r1, r2, rd, u1, u2, rw, ld, br, jp);
        end
        if (last_stall) chk("stall_bound", 1, 0);
    endtask

    // Asynchronous reset in mid-cycle, check reset values, release
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 0;
        #1;
        chk("rst_pc_write", pc_write, 1);
        chk("rst_ifid_write", ifid_write, 1);
        chk("rst_flush", ifid_flush, 0);
        chk("rst_bubble", idex_bubble, 0);
        chk("rst_cmp1", cmp1, 1);
        chk("rst_cmp2", cmp2, 1);
        chk("rst_fwd_a", ex_fwd_a_sel, 0);
        chk("rst_fwd_b", ex_fwd_b_sel, 0);
        chk("rst_state", hcu_state, 0);
        model_clear();
        id_valid = 0; id_jump = 0; id_is_branch = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1;
    endtask

    initial begin
        reset = 0;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_regwrite = 0; id_memread = 0;
        id_is_branch = 0; id_jump = 0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1;

        // Load rd=4 then sub reading x4: one stall, sub reaches EX with WB forward
        issue(0, 0, 4, 0, 0, 1, 1, 0, 0);
        issue(4, 0, 1, 1, 0, 1, 0, 0, 0);
        chk("t2_stalls", stalls_seen, 1);
        #2 chk("t2_fwd_a", ex_fwd_a_sel, 2);

        // add rd=5 then add reading x5 as rs2: no stall, MEM forward
        issue(0, 0, 5, 0, 0, 1, 0, 0, 0);
        issue(0, 5, 2, 0, 1, 1, 0, 0, 0);
        chk("t3_stalls", stalls_seen, 0);
        #2 chk("t3_fwd_b", ex_fwd_b_sel, 1);

        // add rd=6 then taken branch on x6: one stall, then forwarded compare and flush
        issue(0, 0, 6, 0, 0, 1, 0, 0, 0);
        issue(6, 0, 0, 1, 0, 0, 0, 1, 1);
        chk("t4_stalls", stalls_seen, 1);
        chk("t4_flush", last_flush, 1);
        #2 chk("t4_state", hcu_state, 2);
        step(1, 0, 0, 2, 0, 0, 1, 0, 0, 0);
        step(1, 2, 0, 3, 1, 0, 1, 0, 0, 0);

        // Load rd=3 then branch on x3 as rs2: two stalls, then compare from RF
        do_reset();
        issue(0, 0, 3, 0, 0, 1, 1, 0, 0);
        issue(0, 3, 0, 0, 1, 0, 0, 1, 0);
        chk("t5_stalls", stalls_seen, 2);
`ifdef HAZARD_PERF_EN
        #2;
        chk("t5_stall_count", stall_count, 2);
        chk("t5_flush_count", flush_count, 0);
`endif

        // Writer of x0 then reader of x0: no stall, no forward
        issue(0, 0, 0, 0, 0, 1, 1, 0, 0);
        issue(0, 0, 1, 1, 0, 1, 0, 1, 0);
        chk("t6_stalls", stalls_seen, 0);
        #2 chk("t6_fwd_a", ex_fwd_a_sel, 0);

        // Random traffic with a reset in the middle
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            step($urandom_range(0, 7) != 0,
                 3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
